// File: rtl/splat_pkg.sv
// rtl/splat_pkg.sv - shared constants, fetch-state encoding and burst-length helper for the splat fetch path
//
// Purpose: common definitions for the DDR3 -> splat FIFO fetch controller and its parent.
// Contents:
//   SPLAT_FIFO_DEPTH, SPLAT_MAX_BURST, SPLAT_DDR_AW : default geometry
//   splat_fetch_state_t                             : controller state encoding
//   splat_burst_len(addr, remaining)                : words in the next boundary-respecting burst
package splat_pkg;

  localparam int SPLAT_FIFO_DEPTH = 32;
  localparam int SPLAT_MAX_BURST  = 8;
  localparam int SPLAT_DDR_AW     = 29;
  localparam int SPLAT_BURST_LB   = $clog2(SPLAT_MAX_BURST);

  typedef enum logic [2:0] {
    IDLE,
    CREDIT,
    ISSUE,
    DRAIN,
    ABORT,
    FLUSH
  } splat_fetch_state_t;

  // A burst never crosses a MAX_BURST-aligned boundary, so it is limited both by
  // the words left in the job and by the room left in the current aligned block.
  function automatic logic [7:0] splat_burst_len(input logic [SPLAT_DDR_AW-1:0] addr,
                                                 input logic [15:0]             remaining);
    logic [15:0] room;
    room = 16'(SPLAT_MAX_BURST) - 16'(addr[SPLAT_BURST_LB-1:0]);
    return (remaining < room) ? remaining[7:0] : room[7:0];
  endfunction

endpackage

// File: rtl/splat_fetch_ctrl.sv
// rtl/splat_fetch_ctrl.sv - credit-limited DDR3 read-burst controller that fills the splat word FIFO
//
// Purpose: fetches num_words_i 64-bit words starting at base_addr_i from DDR3 in aligned
// bursts, writing returned data straight into the splat FIFO. Bursts are only issued when
// FIFO occupancy + words in flight + the new burst fit in the FIFO, so the FIFO never
// overflows. An abort drains all in-flight reads (discarding them) and then flushes the FIFO.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-high reset
//   start_i, abort_i          : job start (honoured when idle) / job cancel pulses
//   base_addr_i, num_words_i  : job parameters, latched on start
//   busy_o, done_o            : job or abort in progress / one-cycle normal completion pulse
//   ddr_addr_o, ddr_burstcnt_o, ddr_rd_o, ddr_busy_i : DDR3 read request with waitrequest
//   ddr_dout_i, ddr_dout_ready_i                     : DDR3 read data return
//   fifo_wr_data_o, fifo_wr_en_o, fifo_count_i, fifo_flush_o : FIFO write side
module splat_fetch_ctrl
  import splat_pkg::*;
#(
  parameter int FIFO_DEPTH = SPLAT_FIFO_DEPTH,
  parameter int MAX_BURST  = SPLAT_MAX_BURST,
  parameter int AW         = SPLAT_DDR_AW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [15:0]   num_words_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] ddr_addr_o,
  output logic [7:0]    ddr_burstcnt_o,
  output logic          ddr_rd_o,
  input  logic          ddr_busy_i,
  input  logic [63:0]   ddr_dout_i,
  input  logic          ddr_dout_ready_i,
  output logic [63:0]   fifo_wr_data_o,
  output logic          fifo_wr_en_o,
  input  logic [5:0]    fifo_count_i,
  output logic          fifo_flush_o
);

  localparam int LB = $clog2(MAX_BURST);

  splat_fetch_state_t state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [5:0]         outstanding_q, outstanding_d;
  logic               abort_pend_q, abort_pend_d;
  logic               done_q, done_d;

  logic [15:0]        room;
  logic [15:0]        burst_len;
  logic [6:0]         credit_sum;
  logic               credit_ok;
  logic               accept;

  // Burst sizing and credit. The sum is 7 bits wide so a full FIFO plus a full
  // in-flight window plus one more burst cannot wrap.
  always_comb begin
    room       = 16'(MAX_BURST) - 16'(addr_q[LB-1:0]);
    burst_len  = (remaining_q < room) ? remaining_q : room;
    credit_sum = 7'(fifo_count_i) + 7'(outstanding_q) + 7'(burst_len);
    credit_ok  = credit_sum <= 7'(FIFO_DEPTH);
    accept     = (state_q == ISSUE) && !ddr_busy_i;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    // An acceptance and a data return in the same cycle net to n-1.
    outstanding_d = outstanding_q
                  + (accept ? 6'(burst_len) : 6'd0)
                  - (ddr_dout_ready_i ? 6'd1 : 6'd0);

    ddr_rd_o       = 1'b0;
    ddr_addr_o     = '0;
    ddr_burstcnt_o = '0;
    fifo_flush_o   = 1'b0;
    fifo_wr_en_o   = ddr_dout_ready_i;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_words_i == 16'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d       = base_addr_i;
            remaining_d  = num_words_i;
            abort_pend_d = 1'b0;
            state_d      = CREDIT;
          end
        end
      end
      CREDIT: begin
        if (abort_pend_q || abort_i) state_d = ABORT;
        else if (remaining_q == 16'd0) state_d = DRAIN;
        else if (credit_ok) state_d = ISSUE;
      end
      ISSUE: begin
        ddr_rd_o       = 1'b1;
        ddr_addr_o     = addr_q;
        ddr_burstcnt_o = burst_len[7:0];
        // A held request cannot be withdrawn; remember the abort and act on it
        // once the request has been accepted and counted.
        if (abort_i) abort_pend_d = 1'b1;
        if (!ddr_busy_i) begin
          addr_d      = addr_q + AW'(burst_len);
          remaining_d = remaining_q - burst_len;
          state_d     = CREDIT;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_d = ABORT;
        end else if (outstanding_q == 6'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ABORT: begin
        fifo_wr_en_o = 1'b0;
        abort_pend_d = 1'b0;
        if (outstanding_q == 6'd0) state_d = FLUSH;
      end
      FLUSH: begin
        fifo_wr_en_o = 1'b0;
        fifo_flush_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      abort_pend_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      abort_pend_q  <= abort_pend_d;
      done_q        <= done_d;
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign fifo_wr_data_o = ddr_dout_i;

  a_outstanding_max: assert property (@(posedge clk_i) disable iff (reset_i)
    outstanding_q <= 6'(FIFO_DEPTH));
  a_outstanding_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    ddr_dout_ready_i |-> (outstanding_q != 6'd0));

endmodule
